// File: rtl/turbo_intlv_sched_if.sv
// Handshake/bus bundle between the turbo interleave scheduler and its environment
// (frame source, interleave RAM, permute stage and SISO decoder).
interface turbo_intlv_sched_if #(
    parameter int unsigned AW  = 7,
    parameter int unsigned ITW = 3
);
    logic           start;
    logic           in_valid;
    logic           in_ready;
    logic           mem_we;
    logic [AW-1:0]  wr_addr;
    logic           dec_ready;
    logic           rd_valid;
    logic [AW-1:0]  rd_addr;
    logic           swap_en;
    logic           half;
    logic [ITW-1:0] iter;
    logic           busy;
    logic           done;

    modport master (
        output start, in_valid, dec_ready,
        input  in_ready, mem_we, wr_addr, rd_valid, rd_addr,
               swap_en, half, iter, busy, done
    );

    modport slave (
        input  start, in_valid, dec_ready,
        output in_ready, mem_we, wr_addr, rd_valid, rd_addr,
               swap_en, half, iter, busy, done
    );
endinterface

// File: rtl/turbo_intlv_sched.sv
// Turbo decoder iteration scheduler: natural-order frame load, then MAX_ITER
// iterations of a natural-order half (DEC1) and a row/column-interleaved half (DEC2).
module turbo_intlv_sched #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 16,
    parameter int unsigned AW       = 7,
    parameter int unsigned MAX_ITER = 4,
    parameter int unsigned ITW      = 3
) (
    input  logic                clk,
    input  logic                rst,
    turbo_intlv_sched_if.slave  bus
);
    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DEC1,
        S_DEC2,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  wr_addr_q, wr_addr_d;
    logic [AW-1:0]  rd_addr_q, rd_addr_d;
    logic [RW-1:0]  r_q, r_d;
    logic [CW-1:0]  c_q, c_d;
    logic [ITW-1:0] iter_q, iter_d;
    logic           in_ready_q, in_ready_d;
    logic           rd_valid_q, rd_valid_d;
    logic           swap_en_q, swap_en_d;
    logic           half_q, half_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic wr_hs, rd_hs;
    logic wr_last, k_last, r_last, c_last, it_last;

    assign wr_hs   = bus.in_valid & in_ready_q;
    assign rd_hs   = rd_valid_q & bus.dec_ready;
    assign wr_last = (wr_addr_q == AW'(N - 1));
    assign k_last  = (rd_addr_q == AW'(N - 1));
    assign r_last  = (r_q == RW'(ROWS - 1));
    assign c_last  = (c_q == CW'(COLS - 1));
    assign it_last = (iter_q == ITW'(MAX_ITER - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            r_q        <= '0;
            c_q        <= '0;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            swap_en_q  <= 1'b0;
            half_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            r_q        <= r_d;
            c_q        <= c_d;
            iter_q     <= iter_d;
            in_ready_q <= in_ready_d;
            rd_valid_q <= rd_valid_d;
            swap_en_q  <= swap_en_d;
            half_q     <= half_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // DEC2 address r*COLS+c is built incrementally: +COLS per row step, c+1 on row wrap.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        r_d       = r_q;
        c_d       = c_q;
        iter_d    = iter_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    wr_addr_d = '0;
                end
            end
            S_LOAD: begin
                if (wr_hs) begin
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_last) begin
                        state_d   = S_DEC1;
                        rd_addr_d = '0;
                        iter_d    = '0;
                    end
                end
            end
            S_DEC1: begin
                if (rd_hs) begin
                    if (k_last) begin
                        state_d   = S_DEC2;
                        rd_addr_d = '0;
                        r_d       = '0;
                        c_d       = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + AW'(1);
                    end
                end
            end
            S_DEC2: begin
                if (rd_hs) begin
                    if (!r_last) begin
                        r_d       = r_q + RW'(1);
                        rd_addr_d = rd_addr_q + AW'(COLS);
                    end else if (!c_last) begin
                        r_d       = '0;
                        c_d       = c_q + CW'(1);
                        rd_addr_d = AW'(c_q) + AW'(1);
                    end else if (it_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_DEC1;
                        iter_d    = iter_q + ITW'(1);
                        rd_addr_d = '0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        in_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        swap_en_d  = 1'b0;
        half_d     = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;
        unique case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_LOAD: in_ready_d = 1'b1;
            S_DEC1: rd_valid_d = 1'b1;
            S_DEC2: begin
                rd_valid_d = 1'b1;
                swap_en_d  = 1'b1;
                half_d     = 1'b1;
            end
            S_DONE:  done_d = 1'b1;
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.in_ready = in_ready_q;
    assign bus.mem_we   = wr_hs;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.swap_en  = swap_en_q;
    assign bus.half     = half_q;
    assign bus.iter     = iter_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_turbo_intlv_sched.sv
// Scoreboard bench for turbo_intlv_sched: expected write/read address streams are
// queued by the stimulus and popped by a negedge monitor on every handshake.
module tb_turbo_intlv_sched;
    localparam int unsigned ROWS     = 8;
    localparam int unsigned COLS     = 16;
    localparam int unsigned N        = ROWS * COLS;
    localparam int unsigned AW       = 7;
    localparam int unsigned MAX_ITER = 4;
    localparam int unsigned ITW      = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turbo_intlv_sched_if #(.AW(AW), .ITW(ITW)) bus_if ();

    turbo_intlv_sched #(
        .ROWS(ROWS), .COLS(COLS), .AW(AW), .MAX_ITER(MAX_ITER), .ITW(ITW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic           half;
        logic [ITW-1:0] iter;
    } rd_exp_t;

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          done_seen = 0;
    int          done_exp  = 0;
    int unsigned cyc       = 0;
    int unsigned t0;
    logic        mon_en    = 1'b0;
    int          wr_q[$];
    rd_exp_t     rd_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame();
        rd_exp_t e;
        for (int w = 0; w < int'(N); w++) wr_q.push_back(w);
        for (int it = 0; it < int'(MAX_ITER); it++) begin
            for (int k = 0; k < int'(N); k++) begin
                e.addr = AW'(k); e.half = 1'b0; e.iter = ITW'(it);
                rd_q.push_back(e);
            end
            for (int c = 0; c < int'(COLS); c++) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    e.addr = AW'(r * COLS + c); e.half = 1'b1; e.iter = ITW'(it);
                    rd_q.push_back(e);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "_in_ready"}, bus_if.in_ready, 0);
        chk({p, "_mem_we"},   bus_if.mem_we,   0);
        chk({p, "_wr_addr"},  bus_if.wr_addr,  0);
        chk({p, "_rd_valid"}, bus_if.rd_valid, 0);
        chk({p, "_rd_addr"},  bus_if.rd_addr,  0);
        chk({p, "_swap_en"},  bus_if.swap_en,  0);
        chk({p, "_half"},     bus_if.half,     0);
        chk({p, "_iter"},     bus_if.iter,     0);
        chk({p, "_busy"},     bus_if.busy,     0);
        chk({p, "_done"},     bus_if.done,     0);
    endtask

    task automatic chk_after_done(input string p);
        chk({p, "_busy"},     bus_if.busy,     0);
        chk({p, "_done"},     bus_if.done,     0);
        chk({p, "_iter"},     bus_if.iter,     MAX_ITER - 1);
        chk({p, "_half"},     bus_if.half,     0);
        chk({p, "_swap_en"},  bus_if.swap_en,  0);
        chk({p, "_rd_valid"}, bus_if.rd_valid, 0);
    endtask

    // Monitor: every write/read handshake and done pulse is checked against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_if.mem_we) begin
                if (wr_q.size() == 0) chk("wr_queue_has_entry", 0, 1);
                else chk("wr_addr", bus_if.wr_addr, wr_q.pop_front());
            end
            if (bus_if.rd_valid && bus_if.dec_ready) begin
                if (rd_q.size() == 0) chk("rd_queue_has_entry", 0, 1);
                else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    chk("rd_addr", bus_if.rd_addr, e.addr);
                    chk("rd_half", bus_if.half,    e.half);
                    chk("rd_swap", bus_if.swap_en, e.half);
                    chk("rd_iter", bus_if.iter,    e.iter);
                end
            end
            if (bus_if.done) begin
                done_seen++;
                chk("done_busy",     bus_if.busy,     1);
                chk("done_rd_valid", bus_if.rd_valid, 0);
            end
        end
    end

    initial begin
        bus_if.start     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.dec_ready = 1'b0;

        // Random activity before reset, then 3 reset cycles with random inputs.
        repeat (4) begin
            tick();
            bus_if.start     = 1'($urandom_range(0, 1));
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.dec_ready = 1'($urandom_range(0, 1));
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            bus_if.start     = 1'($urandom_range(0, 1));
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.dec_ready = 1'($urandom_range(0, 1));
        end
        chk_all_zero("reset");
        bus_if.start     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.dec_ready = 1'b0;
        rst    = 1'b1;
        mon_en = 1'b1;

        // Frame A: full load, DEC1 stall at address 37, run to done.
        push_frame();
        done_exp++;
        tick();
        bus_if.start = 1'b1;
        tick();
        bus_if.start     = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.dec_ready = 1'b1;
        chk("A_load_in_ready", bus_if.in_ready, 1);
        chk("A_load_wr_addr",  bus_if.wr_addr,  0);
        chk("A_load_busy",     bus_if.busy,     1);
        for (int i = 0; i < 300 && !(bus_if.mem_we && bus_if.wr_addr == AW'(N - 1)); i++) tick();
        chk("A_last_write_seen", int'(bus_if.mem_we && bus_if.wr_addr == AW'(N - 1)), 1);
        tick();
        chk("A_dec1_in_ready", bus_if.in_ready, 0);
        chk("A_dec1_rd_valid", bus_if.rd_valid, 1);
        chk("A_dec1_rd_addr",  bus_if.rd_addr,  0);
        chk("A_dec1_half",     bus_if.half,     0);
        chk("A_dec1_iter",     bus_if.iter,     0);
        for (int i = 0; i < 300 && !(bus_if.rd_valid && !bus_if.half && bus_if.rd_addr == AW'(37)); i++) tick();
        chk("A_addr37_seen", int'(bus_if.rd_valid && !bus_if.half && bus_if.rd_addr == AW'(37)), 1);
        bus_if.dec_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk("A_stall_rd_addr",  bus_if.rd_addr,  37);
            chk("A_stall_rd_valid", bus_if.rd_valid, 1);
            tick();
        end
        bus_if.dec_ready = 1'b1;
        chk("A_stall_end_rd_addr", bus_if.rd_addr, 37);
        tick();
        chk("A_after_stall_rd_addr", bus_if.rd_addr, 38);
        for (int i = 0; i < 3000 && !bus_if.done; i++) tick();
        chk("A_done_seen", bus_if.done, 1);
        tick();
        chk_after_done("A_idle");
        chk("A_rd_queue_drained", rd_q.size(), 0);
        chk("A_wr_queue_drained", wr_q.size(), 0);

        // Frame B: no stalls, done latency, start pulses while busy are ignored.
        push_frame();
        done_exp++;
        tick();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        chk("B_first_handshake", bus_if.mem_we, 1);
        t0 = cyc;
        for (int i = 0; i < 3000 && !bus_if.done; i++) begin
            tick();
            bus_if.start = (i == 40 || i == 700);
        end
        bus_if.start = 1'b0;
        chk("B_done_seen",    bus_if.done, 1);
        chk("B_done_latency", int'(cyc - t0), N + 2 * N * MAX_ITER);
        tick();
        chk_after_done("B_idle");
        chk("B_rd_queue_drained", rd_q.size(), 0);

        // Frame C: reset at the DEC2 handshake with rd_addr=50, iter=2, then restart.
        push_frame();
        tick();
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        for (int i = 0; i < 3000 && !(bus_if.rd_valid && bus_if.half && bus_if.iter == ITW'(2)
                                      && bus_if.rd_addr == AW'(50)); i++) tick();
        chk("C_addr50_seen", int'(bus_if.rd_valid && bus_if.half && bus_if.iter == ITW'(2)
                                  && bus_if.rd_addr == AW'(50)), 1);
        rst = 1'b0;
        tick();
        chk_all_zero("C_reset");
        rd_q.delete();
        chk("C_wr_queue_drained", wr_q.size(), 0);
        for (int w = 0; w < 4; w++) wr_q.push_back(w);
        rst          = 1'b1;
        bus_if.start = 1'b1;
        tick();
        bus_if.start = 1'b0;
        chk("C_restart_in_ready", bus_if.in_ready, 1);
        chk("C_restart_wr_addr",  bus_if.wr_addr,  0);
        chk("C_restart_busy",     bus_if.busy,     1);
        repeat (4) tick();
        bus_if.in_valid  = 1'b0;
        bus_if.dec_ready = 1'b0;
        tick();
        chk("C_restart_wr_addr_after4", bus_if.wr_addr, 4);
        chk("C_restart_wr_queue", wr_q.size(), 0);
        chk("done_pulse_count", done_seen, done_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
